pact_bq_mem_responder: RTL and testbench
========================================

// Module: pact_bq_mem_responder
// PURPOSE
// - Target (responder) end of the PACT bq/bp request-response bus driven by LSU-side initiators.
// - Accepts one request per cycle and serves it from a local word-addressed register-array memory.
// - Returns exactly one in-order bp response per accepted request.
// - Used as a local SPM/shared-buffer target beside LSU nodes and as a bus model for LSU verification.
// PARAMETERS
// - BW_ADDR    32  request address width
// - BW_DATA    32  data width (wvalue, rvalue); multiple of 8, power of two
// - DEPTH      256 memory words; power of two, >=2
// - BASE_ADDR  0   byte address of word 0
// PORTS
// - clk           in   1          single clock; all state on rising edge
// - rst           in   1          asynchronous, active-high reset
// - rbqhint       in   1          initiator hint; ignored, accepted for interface completeness
// - rbqvalid      in   1          request valid
// - rbqready      out  1          request ready
// - rbqwrite      in   1          1=write, 0=read
// - rbqaddr       in   BW_ADDR    byte address
// - rbqwvalue     in   BW_DATA    write data
// - rbqwstrb      in   BW_DATA/8  byte-lane write enables
// - rbpvalid      out  1          response valid
// - rbpready      in   1          response ready
// - rbprvalue     out  BW_DATA    read data (0 for writes / out-of-range)
// - range_error   out  1          sticky; set on any out-of-range request
// - error_clear   in   1          synchronous clear of range_error
// BEHAVIOUR
// - Reset (async, active-high): rbqready=0 while rst asserted; rbpvalid=0, rbprvalue=0, range_error=0, credit count=0, FIFO pointers=0.
// - Memory contents are not reset.
// - Accept: rbqvalid & rbqready at edge t.
// - Index: idx = (rbqaddr - BASE_ADDR) >> log2(BW_DATA/8); the low offset bits are ignored.
// - In range: rbqaddr >= BASE_ADDR and idx < DEPTH; compare at BW_ADDR+1 bits so there is no wrap-around.
// - Write, in range: for each lane i with rbqwstrb[i]=1, mem[idx] lane i <= rbqwvalue lane i at edge t. Response data = 0.
// - Read, in range: response data = mem[idx] as of before edge t.
// - Out of range: write dropped; read data = 0; range_error <= 1.
// - error_clear and a new error in the same cycle: set wins.
// - Response FIFO: depth 2, registered. The entry is written at edge t; rbpvalid=1 from cycle t+1 (latency 1).
// - FIFO head drives rbprvalue; it holds stable while rbpvalid & !rbpready.
// - Credits: count = accepted - retired; range 0..2.
// - rbqready = !rst & (count < 2). rbqready is registered-path only; there is no combinational rbpready->rbqready path.
// - Accept and retire in the same cycle: count unchanged. Sustains 1 req/cycle while rbpready=1.
// - Ordering: responses return strictly in acceptance order.
// - Back-to-back write then read to the same idx: the read returns the new data (array updated at write edge).
// - Full: count==2 -> rbqready=0 until an rbp handshake; stalled rbq* are not sampled.
// - Empty: rbpvalid=0 and rbprvalue holds its last value.
// - Reset mid-operation: all in-flight responses are discarded and no partial handshake completes. Memory is kept.
// STRUCTURE
// - Shared package/header (pact_bq_pkg.vh): BW_BQ_STRB(BW_DATA) macro, RESP_FIFO_DEPTH=2, log2 helper.
// - Sub-module pact_bq_resp_fifo: 2-entry BW_DATA FIFO with push/pop/full/empty and async active-high reset.
// - Top: address decode, strobe-masked write array, credit counter, error flag.
// STRUCTURE NOTES
// - Single write port, single read port on the array; the read is taken at accept.
// TESTING
// - Reset: assert rst mid-burst with 2 responses pending -> rbpvalid=0 next edge, count=0. After release, rbqready=1 and mem[3] keeps 0x1234_5678.
// - Write/read: write 0xDEADBEEF strb 4'hF @0x10, then read @0x10 next cycle -> rbprvalue=0xDEADBEEF one cycle after read accept.
// - Strobes: mem=0x11223344; write 0xAABBCCDD strb 4'b0101 -> read returns 0x11BB33DD.
// - Backpressure: rbpready=0, issue 3 reads -> 2 accepted, rbqready=0. Then rbpready=1 -> responses returned in order, third accepted the cycle after the first retire.
// - Throughput: 16 back-to-back reads with rbpready=1 -> 16 responses in 17 cycles, rbqready never drops.
// - Range: read @BASE_ADDR+DEPTH*4 -> rvalue=0 and range_error=1. Out-of-range write leaves memory unchanged. error_clear -> 0; clear+error same cycle -> stays 1.

Source files
------------

// File: rtl/pact_bq_pkg.sv
// pact_bq_pkg: shared constants and helpers for the PACT bq/bp responder.
package pact_bq_pkg;
    localparam int RESP_FIFO_DEPTH = 2;
    function automatic int bw_bq_strb(input int bw_data);
        return bw_data / 8;
    endfunction
    function automatic int log2c(input int v);
        return $clog2(v);
    endfunction
endpackage

// File: rtl/pact_bq_resp_fifo.sv
// pact_bq_resp_fifo: 2-entry in-order response FIFO; the head register keeps its
// last value after draining so the bus data holds while idle.
module pact_bq_resp_fifo
    import pact_bq_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    logic [1:0]   cnt_q, cnt_d;
    logic [W-1:0] h0_q, h0_d, h1_q, h1_d;
    logic         do_push, do_pop;

    assign full_o  = cnt_q == 2'(RESP_FIFO_DEPTH);
    assign empty_o = cnt_q == 2'd0;
    assign head_o  = h0_q;

    // Two-slot shift queue: h0 is always the oldest entry.
    always_comb begin
        do_push = push_i & !full_o;
        do_pop  = pop_i & !empty_o;
        cnt_d   = cnt_q + 2'(do_push) - 2'(do_pop);
        h0_d    = (do_pop && cnt_q == 2'd2) ? h1_q :
                  (do_push && (cnt_q == 2'd0 || do_pop)) ? din_i : h0_q;
        h1_d    = (do_push && cnt_q == 2'd1 && !do_pop) ? din_i : h1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            h0_q  <= '0;
            h1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            h0_q  <= h0_d;
            h1_q  <= h1_d;
        end
    end
endmodule

// File: rtl/pact_bq_mem_responder.sv
// pact_bq_mem_responder: bq/bp target serving requests from a local word-addressed
// memory, one request per cycle, in-order responses through a 2-deep FIFO.
module pact_bq_mem_responder
    import pact_bq_pkg::*;
#(
    parameter int BW_ADDR   = 32,
    parameter int BW_DATA   = 32,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rbqhint,
    input  logic                             rbqvalid,
    output logic                             rbqready,
    input  logic                             rbqwrite,
    input  logic [BW_ADDR-1:0]               rbqaddr,
    input  logic [BW_DATA-1:0]               rbqwvalue,
    input  logic [bw_bq_strb(BW_DATA)-1:0]   rbqwstrb,
    output logic                             rbpvalid,
    input  logic                             rbpready,
    output logic [BW_DATA-1:0]               rbprvalue,
    output logic                             range_error,
    input  logic                             error_clear
);
    localparam int LANES = bw_bq_strb(BW_DATA);
    localparam int OFF   = log2c(LANES);
    localparam int AW    = log2c(DEPTH);

    logic [BW_DATA-1:0] mem_q [DEPTH];
    logic [BW_ADDR:0]   diff;
    logic [AW-1:0]      idx;
    logic               in_range, accept, full, empty, err_q, err_d;
    logic [BW_DATA-1:0] resp_data;
    logic               unused_ok;

    // One extra bit on the subtraction flags addresses below BASE_ADDR.
    assign diff      = {1'b0, rbqaddr} - (BW_ADDR + 1)'(BASE_ADDR);
    assign idx       = diff[OFF +: AW];
    assign in_range  = !diff[BW_ADDR] && ((diff >> OFF) < (BW_ADDR + 1)'(DEPTH));
    assign rbqready  = !rst & !full;
    assign accept    = rbqvalid & rbqready;
    assign resp_data = (!rbqwrite && in_range) ? mem_q[idx] : '0;
    assign rbpvalid  = !empty;
    assign range_error = err_q;
    assign unused_ok = ^{rbqhint, diff[OFF-1:0]};

    always_ff @(posedge clk) begin
        if (accept && rbqwrite && in_range)
            for (int i = 0; i < LANES; i++)
                if (rbqwstrb[i]) mem_q[idx][i*8 +: 8] <= rbqwvalue[i*8 +: 8];
    end

    always_comb err_d = (accept & !in_range) | (err_q & !error_clear);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    pact_bq_resp_fifo #(.W(BW_DATA)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .pop_i   (rbpvalid & rbpready),
        .din_i   (resp_data),
        .head_o  (rbprvalue),
        .full_o  (full),
        .empty_o (empty)
    );
endmodule

// File: tb/tb_pact_bq_mem_responder.sv
// tb_pact_bq_mem_responder: directed checks of the bq/bp memory responder.
module tb_pact_bq_mem_responder;
    logic        clk = 0;
    logic        rst = 1;
    logic        rbqhint = 0, rbqvalid = 0, rbqwrite = 0, rbpready = 1, error_clear = 0;
    logic [31:0] rbqaddr = 0, rbqwvalue = 0;
    logic [3:0]  rbqwstrb = 0;
    logic        rbqready, rbpvalid, range_error;
    logic [31:0] rbprvalue;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    pact_bq_mem_responder dut (
        .clk(clk), .rst(rst), .rbqhint(rbqhint), .rbqvalid(rbqvalid), .rbqready(rbqready),
        .rbqwrite(rbqwrite), .rbqaddr(rbqaddr), .rbqwvalue(rbqwvalue), .rbqwstrb(rbqwstrb),
        .rbpvalid(rbpvalid), .rbpready(rbpready), .rbprvalue(rbprvalue),
        .range_error(range_error), .error_clear(error_clear)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        rbqvalid = 1; rbqwrite = w; rbqaddr = a; rbqwvalue = d; rbqwstrb = s;
        cyc();
        rbqvalid = 0;
    endtask

    initial begin
        #1;
        chk("rst_ready", 32'(rbqready), 0);
        chk("rst_pvalid", 32'(rbpvalid), 0);
        chk("rst_rvalue", rbprvalue, 0);
        chk("rst_err", 32'(range_error), 0);
        cyc(); cyc();
        rst = 0;
        #1;
        chk("post_rst_ready", 32'(rbqready), 1);

        req(1, 32'h10, 32'hDEADBEEF, 4'hF);
        chk("wr_pvalid", 32'(rbpvalid), 1);
        chk("wr_rvalue", rbprvalue, 0);
        req(0, 32'h10, 0, 0);
        chk("rd_pvalid", 32'(rbpvalid), 1);
        chk("rd_rvalue", rbprvalue, 32'hDEADBEEF);
        cyc();
        chk("idle_pvalid", 32'(rbpvalid), 0);
        chk("idle_hold", rbprvalue, 32'hDEADBEEF);

        req(1, 32'h20, 32'h11223344, 4'hF);
        req(1, 32'h20, 32'hAABBCCDD, 4'b0101);
        req(0, 32'h20, 0, 0);
        chk("strb_rd", rbprvalue, 32'h11BB33DD);
        req(1, 32'h0C, 32'h12345678, 4'hF);

        req(1, 32'h3FC, 32'hCAFEF00D, 4'hF);
        req(0, 32'h3FC, 0, 0);
        chk("top_word", rbprvalue, 32'hCAFEF00D);
        chk("top_no_err", 32'(range_error), 0);
        req(1, 32'h0, 32'h0, 4'hF);
        req(0, 32'h400, 0, 0);
        chk("oor_rd_val", rbprvalue, 0);
        chk("oor_err", 32'(range_error), 1);
        req(1, 32'h400, 32'hFFFFFFFF, 4'hF);
        req(0, 32'h0, 0, 0);
        chk("oor_wr_drop", rbprvalue, 0);
        error_clear = 1;
        cyc();
        error_clear = 0;
        chk("err_clear", 32'(range_error), 0);
        error_clear = 1;
        req(0, 32'h404, 0, 0);
        error_clear = 0;
        chk("err_set_wins", 32'(range_error), 1);
        error_clear = 1;
        cyc();
        error_clear = 0;
        cyc();

        rbpready = 0;
        rbqvalid = 1; rbqwrite = 0; rbqaddr = 32'h10;
        cyc();
        rbqaddr = 32'h20;
        cyc();
        chk("bp_full_ready", 32'(rbqready), 0);
        chk("bp_head0", rbprvalue, 32'hDEADBEEF);
        rbqaddr = 32'h0C;
        cyc();
        chk("bp_stall_ready", 32'(rbqready), 0);
        chk("bp_stall_head", rbprvalue, 32'hDEADBEEF);
        rbpready = 1;
        cyc();
        chk("bp_head1", rbprvalue, 32'h11BB33DD);
        chk("bp_ready_back", 32'(rbqready), 1);
        cyc();
        rbqvalid = 0;
        chk("bp_head2", rbprvalue, 32'h12345678);
        chk("bp_pvalid2", 32'(rbpvalid), 1);
        cyc();
        chk("bp_drained", 32'(rbpvalid), 0);

        for (int k = 0; k < 16; k++) req(1, 32'h80 + 32'(k) * 4, 32'hA5000000 + 32'(k), 4'hF);
        cyc();
        for (int k = 0; k < 16; k++) begin
            chk("tp_ready", 32'(rbqready), 1);
            req(0, 32'h80 + 32'(k) * 4, 0, 0);
            chk("tp_pvalid", 32'(rbpvalid), 1);
            chk("tp_data", rbprvalue, 32'hA5000000 + 32'(k));
        end
        cyc();
        chk("tp_end", 32'(rbpvalid), 0);

        req(0, 32'h500, 0, 0);
        rbpready = 0;
        req(0, 32'h10, 0, 0);
        req(0, 32'h20, 0, 0);
        chk("mid_full", 32'(rbqready), 0);
        rst = 1;
        #1;
        chk("mid_rst_ready", 32'(rbqready), 0);
        cyc();
        chk("mid_rst_pvalid", 32'(rbpvalid), 0);
        chk("mid_rst_err", 32'(range_error), 0);
        rst = 0;
        rbpready = 1;
        #1;
        chk("mid_rel_ready", 32'(rbqready), 1);
        chk("mid_rel_pvalid", 32'(rbpvalid), 0);
        req(0, 32'h0C, 0, 0);
        chk("mem_kept", rbprvalue, 32'h12345678);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
